// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the BURAQ front-end sequencing controller and the fetch stage.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_IMEM_WAIT,
        ST_HALT_DRAIN,
        ST_HALTED
    } fetch_state_t;

    localparam logic [1:0] PCSEL_PC4  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JAL  = 2'b10;
    localparam logic [1:0] PCSEL_JALR = 2'b11;

    // Target select for a redirecting EX instruction; JAL beats JALR beats branch.
    function automatic logic [1:0] redirect_sel(input logic is_jal, input logic is_jalr);
        if (is_jal) begin
            return PCSEL_JAL;
        end else if (is_jalr) begin
            return PCSEL_JALR;
        end
        return PCSEL_BR;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Per-cycle fetch sequencing: resolves redirects, load-use stalls, imem wait states
// and debug halt/resume into next-PC select, flush and hold controls.
module fetch_seq_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic                 ex_is_jal,
    input  logic                 ex_is_jalr,
    input  logic                 ex_branch_taken,
    input  logic                 load_use_hazard,
    input  logic                 imem_ready,
    input  logic                 halt_req,
    input  logic                 resume_req,
    output logic [1:0]           next_pc_sel,
    output logic                 branch_taken,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [DRAIN_W-1:0] drain_q;
    logic [DRAIN_W-1:0] drain_d;
    logic               halted_q;

    logic       redirect;
    logic       redir_is_br;
    logic       not_taken_br;
    logic [1:0] redir_sel;
    logic       count_inc;

    assign redirect     = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_branch_taken));
    assign redir_sel    = redirect_sel(ex_is_jal, ex_is_jalr);
    assign redir_is_br  = ~ex_is_jal & ~ex_is_jalr;
    assign not_taken_br = ex_valid & ex_is_branch & ~redirect;

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        count_inc    = 1'b0;
        next_pc_sel  = PCSEL_PC4;
        branch_taken = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;

        if (reset) begin
            state_d  = ST_BOOT;
            drain_d  = '0;
            flush_if = 1'b1;
            flush_id = 1'b1;
            pc_hold  = 1'b1;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    pc_hold  = 1'b1;
                    flush_if = 1'b1;
                    state_d  = ST_RUN;
                end

                // IMEM_WAIT with the word returned behaves exactly like RUN.
                ST_RUN, ST_IMEM_WAIT: begin
                    if (redirect) begin
                        next_pc_sel  = redir_sel;
                        branch_taken = redir_is_br;
                        flush_if     = 1'b1;
                        flush_id     = 1'b1;
                        count_inc    = 1'b1;
                    end else begin
                        if (not_taken_br) begin
                            next_pc_sel = PCSEL_BR;
                        end
                        if ((state_q == ST_IMEM_WAIT) && !imem_ready) begin
                            pc_hold  = 1'b1;
                            flush_if = 1'b1;
                        end else if (load_use_hazard) begin
                            pc_hold   = 1'b1;
                            ifid_hold = 1'b1;
                            flush_id  = 1'b1;
                            state_d   = ST_RUN;
                        end else if (!imem_ready) begin
                            pc_hold  = 1'b1;
                            flush_if = 1'b1;
                            state_d  = ST_IMEM_WAIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                        if (halt_req) begin
                            state_d = ST_HALT_DRAIN;
                            drain_d = '0;
                        end
                    end
                end

                // In-flight redirects still load the PC, but fetch stays squashed.
                ST_HALT_DRAIN: begin
                    pc_hold  = 1'b1;
                    flush_if = 1'b1;
                    if (redirect) begin
                        next_pc_sel  = redir_sel;
                        branch_taken = redir_is_br;
                        flush_id     = 1'b1;
                        pc_hold      = 1'b0;
                        count_inc    = 1'b1;
                    end
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end

                ST_HALTED: begin
                    pc_hold  = 1'b1;
                    flush_if = 1'b1;
                    if (resume_req) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    assign halted = halted_q;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_redirect_cnt (
        .clock  (clock),
        .reset  (reset),
        .inc_i  (count_inc),
        .count_o(redirect_count)
    );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the sequencing rules.
module tb_fetch_seq_ctrl;

    localparam int DRAIN   = 4;
    localparam int SMALL_W = 4;
    localparam int SMALL_MAX = (1 << SMALL_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_branch_taken;
    logic load_use_hazard, imem_ready, halt_req, resume_req;

    logic [1:0]  next_pc_sel;
    logic        branch_taken, flush_if, flush_id, pc_hold, ifid_hold, halted;
    logic [15:0] redirect_count;

    logic [1:0]         s_sel;
    logic               s_bt, s_fif, s_fid, s_ph, s_ih, s_halted;
    logic [SMALL_W-1:0] s_count;

    fetch_seq_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_branch_taken(ex_branch_taken),
        .load_use_hazard(load_use_hazard), .imem_ready(imem_ready), .halt_req(halt_req),
        .resume_req(resume_req), .next_pc_sel(next_pc_sel), .branch_taken(branch_taken),
        .flush_if(flush_if), .flush_id(flush_id), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .halted(halted), .redirect_count(redirect_count)
    );

    // Narrow counter instance: same stimulus, reaches saturation quickly.
    fetch_seq_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(SMALL_W)) dut_sat (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_branch_taken(ex_branch_taken),
        .load_use_hazard(load_use_hazard), .imem_ready(imem_ready), .halt_req(halt_req),
        .resume_req(resume_req), .next_pc_sel(s_sel), .branch_taken(s_bt),
        .flush_if(s_fif), .flush_id(s_fid), .pc_hold(s_ph), .ifid_hold(s_ih),
        .halted(s_halted), .redirect_count(s_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the front end's situation.
    bit m_boot, m_wait, m_halt_core, m_halted_out;
    int m_drain;                 // -1 when not draining, else cycles spent draining
    int m_cnt, m_cnt_small;
    logic [6:0] exp_ctl;         // {sel[1:0], branch_taken, flush_if, flush_id, pc_hold, ifid_hold}

    function automatic logic [6:0] ctl_obs();
        return {next_pc_sel, branch_taken, flush_if, flush_id, pc_hold, ifid_hold};
    endfunction

    function automatic logic [6:0] ctl_small();
        return {s_sel, s_bt, s_fif, s_fid, s_ph, s_ih};
    endfunction

    function automatic bit take_redirect();
        return ex_valid && (ex_is_jal || ex_is_jalr || (ex_is_branch && ex_branch_taken));
    endfunction

    function automatic logic [6:0] model_ctl();
        logic [1:0] sel;
        bit bt, fif, fid, ph, ih, r;
        r = take_redirect();
        sel = 2'b00; bt = 0; fif = 0; fid = 0; ph = 0; ih = 0;
        if (reset) begin
            fif = 1; fid = 1; ph = 1;
        end else if (m_boot || m_halt_core) begin
            ph = 1; fif = 1;
        end else if (r) begin
            sel = ex_is_jal ? 2'b10 : (ex_is_jalr ? 2'b11 : 2'b01);
            bt  = !ex_is_jal && !ex_is_jalr;
            fif = 1; fid = 1;
        end else if (m_drain >= 0) begin
            ph = 1; fif = 1;
        end else begin
            if (ex_valid && ex_is_branch) sel = 2'b01;
            if (m_wait && !imem_ready) begin
                ph = 1; fif = 1;
            end else if (load_use_hazard) begin
                ph = 1; ih = 1; fid = 1;
            end else if (!imem_ready) begin
                ph = 1; fif = 1;
            end
        end
        return {sel, bt, fif, fid, ph, ih};
    endfunction

    function automatic void model_update();
        bit r;
        r = take_redirect();
        if (reset) begin
            m_boot = 1; m_wait = 0; m_drain = -1; m_halt_core = 0;
            m_cnt = 0; m_cnt_small = 0;
        end else begin
            if (r && !m_boot && !m_halt_core) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_small < SMALL_MAX) m_cnt_small++;
            end
            if (m_boot) begin
                m_boot = 0;
            end else if (m_halt_core) begin
                if (resume_req) m_halt_core = 0;
            end else if (m_drain >= 0) begin
                if (m_drain == DRAIN - 1) begin
                    m_halt_core = 1; m_drain = -1;
                end else begin
                    m_drain++;
                end
            end else if (!r) begin
                if (halt_req) begin
                    m_drain = 0; m_wait = 0;
                end else if (m_wait) begin
                    m_wait = !imem_ready;
                end else begin
                    m_wait = !load_use_hazard && !imem_ready;
                end
            end
        end
        m_halted_out = m_halt_core;
    endfunction

    task automatic advance();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_branch_taken = 0;
        load_use_hazard = 0; imem_ready = 1; halt_req = 0; resume_req = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        advance();
        reset = 0;
        advance();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            advance();
            #1;
            exp_ctl = model_ctl();
            n_tests++;
            if (ctl_obs() !== 7'b00_0_1_1_1_0 || ctl_obs() !== exp_ctl) begin
                n_fail++; $display("FAIL reset_ctl cyc%0d: got %b want %b", i, ctl_obs(), exp_ctl);
            end
            n_tests++;
            if (halted !== 1'b0 || redirect_count !== 16'h0) begin
                n_fail++; $display("FAIL reset_regs: halted=%b count=%h want 0/0", halted, redirect_count);
            end
        end
        reset = 0;
        #1;
        exp_ctl = model_ctl();
        n_tests++;
        if (ctl_obs() !== 7'b00_0_1_0_1_0 || ctl_obs() !== exp_ctl) begin
            n_fail++; $display("FAIL boot_ctl: got %b want %b", ctl_obs(), exp_ctl);
        end
        advance();
        #1;
        exp_ctl = model_ctl();
        n_tests++;
        if (ctl_obs() !== 7'b0 || ctl_obs() !== exp_ctl) begin
            n_fail++; $display("FAIL run_first_ctl: got %b want %b", ctl_obs(), exp_ctl);
        end
        advance();
    endtask

    task automatic test_branch_loaduse();
        do_reset();
        ex_valid = 1; ex_is_branch = 1; ex_branch_taken = 1; load_use_hazard = 1;
        #1;
        exp_ctl = model_ctl();
        n_tests++;
        if (ctl_obs() !== 7'b01_1_1_1_0_0 || ctl_obs() !== exp_ctl) begin
            n_fail++; $display("FAIL br_lu_ctl: got %b want %b", ctl_obs(), exp_ctl);
        end
        n_tests++;
        if (redirect_count !== 16'd0) begin
            n_fail++; $display("FAIL br_lu_cnt_before: got %0d want 0", redirect_count);
        end
        advance();
        clear_inputs();
        #1;
        n_tests++;
        if (redirect_count !== 16'd1 || redirect_count !== 16'(m_cnt)) begin
            n_fail++; $display("FAIL br_lu_cnt_after: got %0d want 1", redirect_count);
        end
    endtask

    task automatic test_loaduse2();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            load_use_hazard = (k < 2);
            #1;
            exp_ctl = model_ctl();
            n_tests++;
            if (ctl_obs() !== ((k < 2) ? 7'b00_0_0_1_1_1 : 7'b0) || ctl_obs() !== exp_ctl) begin
                n_fail++; $display("FAIL loaduse cyc%0d: got %b want %b", k, ctl_obs(), exp_ctl);
            end
            advance();
        end
    endtask

    task automatic test_imem_jalr();
        logic [4:0] ready_pat = 5'b11000;  // bit k drives cycle k
        logic [4:0] jalr_pat  = 5'b00010;
        logic [6:0] want [5] = '{7'b00_0_1_0_1_0, 7'b11_0_1_1_0_0, 7'b00_0_1_0_1_0,
                                 7'b0, 7'b00_0_0_1_1_1};
        int start_cnt;
        do_reset();
        start_cnt = m_cnt;
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            imem_ready = ready_pat[k];
            ex_valid   = jalr_pat[k];
            ex_is_jalr = jalr_pat[k];
            // Last cycle: imem low with load-use distinguishes RUN from IMEM_WAIT.
            if (k == 4) begin
                imem_ready = 0; load_use_hazard = 1;
            end
            #1;
            exp_ctl = model_ctl();
            n_tests++;
            if (ctl_obs() !== want[k] || ctl_obs() !== exp_ctl) begin
                n_fail++; $display("FAIL imem_jalr cyc%0d: got %b want %b", k, ctl_obs(), want[k]);
            end
            advance();
        end
        clear_inputs();
        #1;
        n_tests++;
        if (redirect_count !== 16'(start_cnt + 1)) begin
            n_fail++; $display("FAIL imem_jalr_cnt: got %0d want %0d", redirect_count, start_cnt + 1);
        end
        advance();
    endtask

    task automatic test_halt_resume();
        do_reset();
        halt_req = 1;
        for (int k = 0; k <= DRAIN + 1; k++) begin
            #1;
            exp_ctl = model_ctl();
            n_tests++;
            if (halted !== (k == DRAIN + 1) || halted !== m_halted_out || ctl_obs() !== exp_ctl) begin
                n_fail++; $display("FAIL halt_latency k=%0d: halted=%b ctl=%b want halted=%b ctl=%b",
                                   k, halted, ctl_obs(), (k == DRAIN + 1), exp_ctl);
            end
            if (k <= DRAIN) advance();
        end
        advance();
        #1;
        n_tests++;
        if (pc_hold !== 1'b1 || halted !== 1'b1) begin
            n_fail++; $display("FAIL halted_hold: pc_hold=%b halted=%b want 1/1", pc_hold, halted);
        end
        resume_req = 1; halt_req = 0;
        #1;
        n_tests++;
        if (pc_hold !== 1'b1 || flush_if !== 1'b1) begin
            n_fail++; $display("FAIL resume_cycle: pc_hold=%b flush_if=%b want 1/1", pc_hold, flush_if);
        end
        advance();
        resume_req = 0;
        #1;
        n_tests++;
        if (pc_hold !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL after_resume: pc_hold=%b halted=%b want 0/0", pc_hold, halted);
        end
        advance();
    endtask

    task automatic test_saturate();
        do_reset();
        ex_valid = 1; ex_is_jal = 1;
        // Bring the narrow counter to all-ones minus one (the 16-bit FFFE case).
        for (int i = 0; i < 40 && m_cnt_small < SMALL_MAX - 1; i++) advance();
        #1;
        n_tests++;
        if (s_count !== SMALL_W'(SMALL_MAX - 1)) begin
            n_fail++; $display("FAIL sat_preload: got %h want %h", s_count, SMALL_MAX - 1);
        end
        for (int j = 0; j < 3; j++) begin
            advance();
            #1;
            n_tests++;
            if (s_count !== SMALL_W'(SMALL_MAX) || redirect_count !== 16'(m_cnt)) begin
                n_fail++; $display("FAIL sat_jal%0d: small=%h wide=%0d want %h/%0d",
                                   j, s_count, redirect_count, SMALL_MAX, m_cnt);
            end
        end
        clear_inputs();
        advance();
        #1;
        n_tests++;
        if (s_count !== SMALL_W'(SMALL_MAX)) begin
            n_fail++; $display("FAIL sat_hold: got %h want %h", s_count, SMALL_MAX);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        halt_req = 1;
        advance(); advance(); advance();
        reset = 1; halt_req = 0;
        #1;
        n_tests++;
        if (ctl_obs() !== 7'b00_0_1_1_1_0) begin
            n_fail++; $display("FAIL mid_reset_ctl: got %b want 0001110", ctl_obs());
        end
        advance();
        reset = 0;
        advance();
        halt_req = 1;
        for (int k = 0; k <= DRAIN + 1; k++) begin
            #1;
            n_tests++;
            if (halted !== (k == DRAIN + 1)) begin
                n_fail++; $display("FAIL mid_reset_drain k=%0d: halted=%b want %b", k, halted, (k == DRAIN + 1));
            end
            if (k <= DRAIN) advance();
        end
        clear_inputs();
        resume_req = 1;
        advance();
        resume_req = 0;
    endtask

    task automatic random_inputs();
        int t;
        t = $urandom_range(0, 3);
        ex_valid        = ($urandom_range(0, 1) == 1);
        ex_is_branch    = (t == 1);
        ex_is_jal       = (t == 2);
        ex_is_jalr      = (t == 3);
        ex_branch_taken = ($urandom_range(0, 1) == 1);
        load_use_hazard = ($urandom_range(0, 3) == 0);
        imem_ready      = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 29) == 0) halt_req = !halt_req;
        resume_req      = ($urandom_range(0, 9) == 0);
        reset           = ($urandom_range(0, 99) == 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            random_inputs();
            #1;
            exp_ctl = model_ctl();
            n_tests++;
            if (ctl_obs() !== exp_ctl || ctl_small() !== exp_ctl) begin
                n_fail++; $display("FAIL rand_ctl c%0d: got %b small %b want %b", c, ctl_obs(), ctl_small(), exp_ctl);
            end
            n_tests++;
            if (halted !== m_halted_out || s_halted !== m_halted_out) begin
                n_fail++; $display("FAIL rand_halted c%0d: got %b/%b want %b", c, halted, s_halted, m_halted_out);
            end
            n_tests++;
            if (redirect_count !== 16'(m_cnt) || s_count !== SMALL_W'(m_cnt_small)) begin
                n_fail++; $display("FAIL rand_count c%0d: got %0d/%0d want %0d/%0d",
                                   c, redirect_count, s_count, m_cnt, m_cnt_small);
            end
            advance();
        end
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_drain = -1;
        clear_inputs();
        test_reset();
        test_branch_loaduse();
        test_loaduse2();
        test_imem_jalr();
        test_halt_resume();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
